// File: rtl/gamma_seq.sv
// -----------------------------------------------------------------------------
// gamma_seq -- gamma-cycle sequencer for temporal (race-logic) datapath units.
//
// Takes a vector of binary arrival times from the host, then frames one gamma
// cycle on the temporal column:
//   * a one-cycle clear pulse (col_rst),
//   * GAMMA_CYCLE_WIDTH-1 run cycles in which every non-NULL lane produces a
//     PULSE_WIDTH-wide spike starting at its arrival time.
// During the run cycles the datapath output line y_in is sampled. Its first
// rise time is converted back to binary, after subtracting DUT_LAT.
//
// Ports
//   aclk       in   clock
//   grst       in   synchronous active-high reset
//   in_valid   in   arrival times valid
//   in_ready   out  sequencer can accept a new time vector
//   in_times   in   N_IN lanes of VAL_W bits, lane i = [i*VAL_W +: VAL_W]
//   col_rst    out  one-cycle clear pulse to the datapath
//   spike      out  N_IN pulse-width-encoded lines to the datapath
//   y_in       in   datapath output line
//   out_valid  out  decoded result valid
//   out_ready  in   consumer accepts result
//   out_time   out  decoded first-rise time of y_in, all-ones (NULL) if none
//
// Build option
//   GAMMA_FREERUN_EN : when defined, the sequencer free-runs once it has been
//   loaded. DONE lasts one cycle, out_ready is ignored, and the FSM goes
//   straight back to CLR. New times may be handed over during DONE. Without a
//   handshake, the last latched times replay.
// -----------------------------------------------------------------------------
module gamma_seq #(
    parameter int N_IN              = 2,
    parameter int VAL_W             = 3,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int DUT_LAT           = 0
) (
    input  logic                    aclk,
    input  logic                    grst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*VAL_W-1:0]   in_times,
    output logic                    col_rst,
    output logic [N_IN-1:0]         spike,
    input  logic                    y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VAL_W-1:0]        out_time
);

    localparam logic [VAL_W-1:0] NULL_T = '1;
    // The counter runs 0..GAMMA_CYCLE_WIDTH-2, which always fits in clog2 bits.
    localparam int               CNT_W  = (GAMMA_CYCLE_WIDTH > 2) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 2);

    // The latest spike (time 2^VAL_W-2) must finish inside the run phase.
    if (((2 ** VAL_W) - 2) + PULSE_WIDTH > GAMMA_CYCLE_WIDTH - 1) begin : g_bad_cfg
        $error("gamma_seq: latest spike does not fit inside the run phase");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE
    } state_t;

    // Pulse-width encoding of one lane at run step k.
    function automatic logic lane_on(input logic [CNT_W-1:0] k, input logic [VAL_W-1:0] t);
        int ki;
        int ti;
        ki = int'(k);
        ti = int'(t);
        return (t != NULL_T) && (ki >= ti) && (ki < ti + PULSE_WIDTH);
    endfunction

    // First-rise step -> binary time. Subtract the latency and clamp at zero.
    // Values that would collide with NULL saturate to NULL.
    function automatic logic [VAL_W-1:0] decode_time(input logic seen, input logic [CNT_W-1:0] k);
        logic signed [31:0] m;
        if (!seen) begin
            return NULL_T;
        end
        m = int'(k) - DUT_LAT;
        if (m < 0) begin
            m = 0;
        end
        if (m >= int'(NULL_T)) begin
            return NULL_T;
        end
        return m[VAL_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_IN*VAL_W-1:0]   times_q, times_d;
    logic [N_IN-1:0]         spike_q, spike_d;
    logic                    seen_q, seen_d;
    logic [CNT_W-1:0]        rise_q, rise_d;
    logic [VAL_W-1:0]        out_time_q, out_time_d;

`ifdef GAMMA_FREERUN_EN
    // In free-run mode the consumer cannot stall the sequencer.
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
`endif

    // Control state. A reset drops any spike that is in flight on the same edge.
    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            spike_q    <= '0;
            seen_q     <= 1'b0;
            rise_q     <= '0;
            out_time_q <= NULL_T;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            spike_q    <= spike_d;
            seen_q     <= seen_d;
            rise_q     <= rise_d;
            out_time_q <= out_time_d;
        end
    end

    // Latched arrival times. This register is pure data, so it has no reset.
    always_ff @(posedge aclk) begin
        times_q <= times_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        times_d    = times_q;
        seen_d     = seen_q;
        rise_d     = rise_q;
        out_time_d = out_time_q;
        spike_d    = '0;
        in_ready   = 1'b0;
        col_rst    = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                cnt_d    = '0;
                if (in_valid) begin
                    times_d = in_times;
                    state_d = S_CLR;
                end
            end

            S_CLR: begin
                col_rst = 1'b1;
                cnt_d   = '0;
                seen_d  = 1'b0;
                rise_d  = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // Only the first rise counts. Later activity on y_in is ignored.
                if (y_in && !seen_q) begin
                    seen_d = 1'b1;
                    rise_d = cnt_q;
                end
                if (cnt_q == K_LAST) begin
                    cnt_d      = '0;
                    out_time_d = decode_time(seen_d, rise_d);
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
`ifdef GAMMA_FREERUN_EN
                in_ready = 1'b1;
                if (in_valid) begin
                    times_d = in_times;
                end
                state_d = S_CLR;
`else
                if (out_ready) begin
                    state_d = S_IDLE;
                end
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // spike is registered from the next-state view. That keeps it aligned
        // with the counter value that the RUN cycle holds.
        if (state_d == S_RUN) begin
            for (int i = 0; i < N_IN; i++) begin
                spike_d[i] = lane_on(cnt_d, times_d[i*VAL_W +: VAL_W]);
            end
        end
    end

    assign spike    = spike_q;
    assign out_time = out_time_q;

endmodule
